// File: rtl/lcd_pkg.sv
// Shared types and init ROM for the HD44780 character LCD sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  typedef enum logic [1:0] {
    W_INIT1,
    W_INIT2,
    W_EXEC,
    W_LONG
  } wait_sel_t;

  localparam int INIT_STEPS = 7;
  localparam int STEP_W     = $clog2(INIT_STEPS);

  typedef logic [STEP_W-1:0] step_t;

  localparam step_t LAST_STEP = step_t'(INIT_STEPS - 1);

  // 8-bit bus, 2 lines, display on / cursor off, clear, entry mode increment.
  function automatic logic [7:0] init_byte(input step_t s);
    case (s)
      3'd0, 3'd1, 3'd2, 3'd3: return 8'h38;
      3'd4:                   return 8'h0C;
      3'd5:                   return 8'h01;
      3'd6:                   return 8'h06;
      default:                return 8'h00;
    endcase
  endfunction

  function automatic wait_sel_t init_wait(input step_t s);
    case (s)
      3'd0:    return W_INIT1;
      3'd1:    return W_INIT2;
      3'd5:    return W_LONG;
      default: return W_EXEC;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Write-only HD44780 sequencer: power-up init, then one byte per valid/ready transfer.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC = 2_400_000,
  parameter int unsigned INIT1_CYC   = 656_000,
  parameter int unsigned INIT2_CYC   = 16_000,
  parameter int unsigned SETUP_CYC   = 16,
  parameter int unsigned EN_CYC      = 80,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned EXEC_CYC    = 8_000,
  parameter int unsigned LONG_CYC    = 320_000,
  parameter bit          BACKLIGHT   = 1'b1
) (
  input  logic       clock_160,
  input  logic       inp_resn,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_blon
);

  localparam int unsigned MAX_CYC =
    max_u(max_u(max_u(POWERUP_CYC, INIT1_CYC), max_u(INIT2_CYC, SETUP_CYC)),
          max_u(max_u(EN_CYC, HOLD_CYC), max_u(EXEC_CYC, LONG_CYC)));
  localparam int CW = $clog2(MAX_CYC + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t ONE = cnt_t'(1);

  // A state loaded with N leaves on the cycle the counter hits zero, i.e. after N cycles.
  function automatic cnt_t load(input int unsigned n);
    return cnt_t'(n - 1);
  endfunction

  function automatic int unsigned wait_cycles(input wait_sel_t sel);
    case (sel)
      W_INIT1: return INIT1_CYC;
      W_INIT2: return INIT2_CYC;
      W_LONG:  return LONG_CYC;
      default: return EXEC_CYC;
    endcase
  endfunction

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  step_t      step_q, step_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       en_q, en_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       cnt_zero;
  wait_sel_t  sel;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clock_160 or negedge inp_resn) begin
    if (!inp_resn) begin
      state_q <= S_PWRUP;
      cnt_q   <= load(POWERUP_CYC);
      step_q  <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = done_q;
    sel     = W_EXEC;

    case (state_q)
      S_PWRUP: begin
        if (cnt_zero) begin
          state_d = S_SETUP;
          cnt_d   = load(SETUP_CYC);
          step_d  = '0;
          rs_d    = 1'b0;
          data_d  = init_byte('0);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_STROBE;
          cnt_d   = load(EN_CYC);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_STROBE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = load(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_HOLD: begin
        // Init steps take their wait from the ROM; requester bytes from the command decode.
        if (done_q) begin
          sel = is_long_cmd(rs_q, data_q) ? W_LONG : W_EXEC;
        end else begin
          sel = init_wait(step_q);
        end
        if (cnt_zero) begin
          state_d = S_WAIT;
          cnt_d   = load(wait_cycles(sel));
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          if (!done_q && (step_q != LAST_STEP)) begin
            state_d = S_SETUP;
            cnt_d   = load(SETUP_CYC);
            step_d  = step_q + step_t'(1);
            rs_d    = 1'b0;
            data_d  = init_byte(step_q + step_t'(1));
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_IDLE: begin
        if (wr_valid && ready_q) begin
          state_d = S_SETUP;
          cnt_d   = load(SETUP_CYC);
          rs_d    = wr_rs;
          data_d  = wr_data;
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = load(POWERUP_CYC);
      end
    endcase
  end

  assign en_d    = (state_d == S_STROBE);
  assign ready_d = (state_d == S_IDLE);

  assign wr_ready  = ready_q;
  assign init_done = done_q;
  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign lcd_en    = en_q;
  assign lcd_on    = 1'b1;
  assign lcd_blon  = BACKLIGHT;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: init sequence, byte timing, handshake and reset corners.
module tb_lcd_ctrl;

  localparam int P_POW   = 20;
  localparam int P_INIT1 = 10;
  localparam int P_INIT2 = 5;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 4;
  localparam int P_LONG  = 12;

  logic       clk;
  logic       rstN;
  logic       wrValid;
  logic       wrRs;
  logic [7:0] wrData;
  logic       wrReady;
  logic       initDone;
  logic [7:0] lcdData;
  logic       lcdRs;
  logic       lcdEn;
  logic       lcdOn;
  logic       lcdBlon;

  int checks = 0;
  int errors = 0;

  logic [8:0] strobeByte[$];
  longint     strobeEdge[$];
  logic [8:0] expQ[$];
  longint     firstEdge;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } vec_t;

  vec_t vecs[8];

  lcd_ctrl #(
    .POWERUP_CYC(P_POW),
    .INIT1_CYC  (P_INIT1),
    .INIT2_CYC  (P_INIT2),
    .SETUP_CYC  (P_SETUP),
    .EN_CYC     (P_EN),
    .HOLD_CYC   (P_HOLD),
    .EXEC_CYC   (P_EXEC),
    .LONG_CYC   (P_LONG),
    .BACKLIGHT  (1'b1)
  ) dut (
    .clock_160(clk),
    .inp_resn (rstN),
    .wr_valid (wrValid),
    .wr_rs    (wrRs),
    .wr_data  (wrData),
    .wr_ready (wrReady),
    .init_done(initDone),
    .lcd_data (lcdData),
    .lcd_rs   (lcdRs),
    .lcd_en   (lcdEn),
    .lcd_on   (lcdOn),
    .lcd_blon (lcdBlon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: init bytes/waits and the per-byte spacing rule.
  function automatic logic [7:0] modelInitByte(input int i);
    logic [7:0] b[7];
    b = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    return b[i];
  endfunction

  function automatic int modelInitWait(input int i);
    int w[7];
    w = '{P_INIT1, P_INIT2, P_EXEC, P_EXEC, P_EXEC, P_LONG, P_EXEC};
    return w[i];
  endfunction

  function automatic int modelGap(input logic rs, input logic [7:0] d);
    bit isLong;
    isLong = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    return P_SETUP + P_EN + P_HOLD + (isLong ? P_LONG : P_EXEC) + 1;
  endfunction

  function automatic int modelInitDoneEdge();
    int t;
    t = P_POW;
    for (int i = 0; i < 7; i++) t += P_SETUP + P_EN + P_HOLD + modelInitWait(i);
    return t;
  endfunction

  function automatic longint edgeIdx(input longint e);
    return (e - firstEdge) / 10 + 1;
  endfunction

  // Bus monitor: records each EN pulse and checks its width and the data setup window.
  logic       enPrev = 1'b0;
  int         enLen  = 0;
  logic [8:0] hist1  = '0;
  logic [8:0] hist2  = '0;

  always @(negedge clk) begin
    if (!rstN) begin
      checkOutput("en_low_in_reset", longint'(lcdEn), 0);
      enPrev = 1'b0;
      enLen  = 0;
    end else begin
      if (lcdEn && !enPrev) begin
        strobeByte.push_back({lcdRs, lcdData});
        strobeEdge.push_back(longint'($time) - 5);
        checkOutput("setup_stable", longint'(hist2), longint'({lcdRs, lcdData}));
        enLen = 0;
      end
      if (lcdEn) enLen++;
      if (!lcdEn && enPrev) checkOutput("en_width", enLen, P_EN);
      enPrev = lcdEn;
    end
    hist2 = hist1;
    hist1 = {lcdRs, lcdData};
  end

  task automatic doReset();
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_en", longint'(lcdEn), 0);
    checkOutput("rst_rs", longint'(lcdRs), 0);
    checkOutput("rst_data", longint'(lcdData), 0);
    checkOutput("rst_ready", longint'(wrReady), 0);
    checkOutput("rst_done", longint'(initDone), 0);
    checkOutput("lcd_on", longint'(lcdOn), 1);
    checkOutput("lcd_blon", longint'(lcdBlon), 1);
    repeat (3) @(negedge clk);
    #2 rstN = 1'b1;
    firstEdge = longint'($time) + 3;
    strobeByte.delete();
    strobeEdge.delete();
    expQ.delete();
    for (int i = 0; i < 7; i++) expQ.push_back({1'b0, modelInitByte(i)});
    @(negedge clk);
  endtask

  task automatic compareStrobes(input string tag);
    checkOutput({tag, "_strobe_count"}, strobeByte.size(), expQ.size());
    for (int i = 0; i < strobeByte.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s_strobe%0d", tag, i), longint'(strobeByte[i]), longint'(expQ[i]));
  endtask

  task automatic waitInit(input string tag);
    bit found = 0;
    bit early = 0;
    for (int i = 0; i < 400; i++) begin
      if (initDone) begin
        found = 1;
        break;
      end
      if (wrReady) early = 1;
      @(negedge clk);
    end
    checkOutput({tag, "_init_found"}, found, 1);
    checkOutput({tag, "_init_done_edge"}, edgeIdx(longint'($time) - 5), modelInitDoneEdge());
    checkOutput({tag, "_ready_with_done"}, longint'(wrReady), 1);
    checkOutput({tag, "_ready_before_done"}, early, 0);
    if (strobeEdge.size() > 0)
      checkOutput({tag, "_first_en_edge"}, edgeIdx(strobeEdge[0]), P_POW + P_SETUP);
    compareStrobes(tag);
  endtask

  // Present a byte (called at a negedge) and return the posedge time it was accepted.
  task automatic applyStimulus(input logic rs, input logic [7:0] d, input int bound,
                               output longint acc);
    wrRs    = rs;
    wrData  = d;
    wrValid = 1'b1;
    acc     = -1;
    for (int i = 0; i < bound; i++) begin
      if (wrReady) begin
        @(posedge clk);
        acc = longint'($time);
        expQ.push_back({rs, d});
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: byte 0x%0h never accepted within %0d cycles", d, bound);
    end
  endtask

  task automatic readyGap(input longint acc, output int gap);
    gap = -1;
    for (int i = 0; i < 400; i++) begin
      if (wrReady) begin
        gap = int'((longint'($time) + 5 - acc) / 10);
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    longint acc;
    longint accs[8];
    int     gap;
    int     sel;
    int     idle;
    logic   rrs;
    logic [7:0] rd;

    vecs[0] = '{1'b1, 8'h41, 12};
    vecs[1] = '{1'b0, 8'h01, 20};
    vecs[2] = '{1'b0, 8'h80, 12};
    vecs[3] = '{1'b0, 8'h02, 20};
    vecs[4] = '{1'b0, 8'h03, 20};
    vecs[5] = '{1'b0, 8'h00, 12};
    vecs[6] = '{1'b0, 8'h04, 12};
    vecs[7] = '{1'b1, 8'h01, 12};

    rstN    = 1'b1;
    wrValid = 1'b0;
    wrRs    = 1'b0;
    wrData  = 8'h00;
    #1 rstN = 1'b0;

    $display("[TB] power-up init sequence");
    doReset();
    waitInit("init");

    $display("[TB] single data write");
    applyStimulus(1'b1, 8'h41, 50, acc);
    wrValid = 1'b0;
    readyGap(acc, gap);
    checkOutput("data41_ready_gap", gap, 12);
    checkOutput("idle_hold_data", longint'(lcdData), 8'h41);
    checkOutput("idle_hold_rs", longint'(lcdRs), 1);

    $display("[TB] back-to-back vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].data, 100, accs[i]);
      if (i > 0)
        checkOutput($sformatf("vec%0d_gap", i - 1), (accs[i] - accs[i-1]) / 10, vecs[i-1].gap);
    end
    wrValid = 1'b0;
    readyGap(accs[7], gap);
    checkOutput("vec7_gap", gap, vecs[7].gap);
    compareStrobes("vec");

    $display("[TB] valid held through init");
    wrValid = 1'b1;
    wrRs    = 1'b1;
    wrData  = 8'h55;
    doReset();
    applyStimulus(1'b1, 8'h55, 400, acc);
    wrValid = 1'b0;
    checkOutput("held_accept_edge", edgeIdx(acc), modelInitDoneEdge() + 1);
    checkOutput("held_no_early_strobe", strobeByte.size(), 7);
    readyGap(acc, gap);
    checkOutput("held_ready_gap", gap, 12);
    compareStrobes("held");

    $display("[TB] reset during strobe");
    applyStimulus(1'b1, 8'h77, 50, acc);
    wrValid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (lcdEn) break;
      @(negedge clk);
    end
    checkOutput("strobe_reached", longint'(lcdEn), 1);
    doReset();
    waitInit("rst");

    $display("[TB] streamed data bytes");
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom_range(32, 126));
      applyStimulus(1'b1, rd, 100, accs[i]);
      if (i > 0) checkOutput($sformatf("stream%0d_gap", i - 1), (accs[i] - accs[i-1]) / 10, 12);
    end
    wrValid = 1'b0;
    readyGap(accs[2], gap);
    checkOutput("stream2_gap", gap, 12);
    compareStrobes("stream");

    $display("[TB] randomized writes");
    for (int i = 0; i < 20; i++) begin
      sel  = int'($urandom_range(0, 3));
      rrs  = 1'($urandom_range(0, 1));
      rd   = (sel == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      idle = int'($urandom_range(0, 3));
      repeat (idle) @(negedge clk);
      applyStimulus(rrs, rd, 100, acc);
      wrValid = 1'b0;
      readyGap(acc, gap);
      checkOutput($sformatf("rand%0d_gap", i), gap, modelGap(rrs, rd));
    end
    compareStrobes("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
